// File: rtl/systolic_host_pkg.sv
// Shared types and sizing helpers for the systolic host sequencer.
// Holds the FSM state encoding and counter/address width rules.
package systolic_host_pkg;

  localparam int N_DEF  = 8;
  localparam int ADDR_W = $clog2(N_DEF * N_DEF);
  localparam int CNT_W  = $clog2(N_DEF * N_DEF + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD_N,
    LOAD_W,
    START,
    WAIT_COMP,
    DRAIN,
    FINISH
  } state_t;

  function automatic int addr_w(input int n);
    return $clog2(n * n);
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n * n + 1);
  endfunction

endpackage

// File: rtl/systolic_host_sequencer_fifo.sv
// host_result_fifo: 2-entry synchronous FIFO buffering SRAM read results.
// Ports: push_i/din_i write, pop_i read, flush_i clear, count_o, head_o.
module host_result_fifo #(
  parameter int W = 33
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [2];
  logic         wp_q;
  logic         rp_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign do_push = push_i && (cnt_q != 2'd2);
  assign do_pop  = pop_i && (cnt_q != 2'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) wp_q <= ~wp_q;
      if (do_pop)  rp_q <= ~rp_q;
      cnt_q <= cnt_q + {1'b0, do_push}
                     - {1'b0, do_pop};
    end
  end

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end

  assign count_o = cnt_q;
  assign head_o  = (cnt_q != 2'd0) ? mem_q[rp_q] : '0;

endmodule

// File: rtl/systolic_host_sequencer.sv
// Host-side job sequencer: loads north/west queues from an inbound stream,
// starts the multiply, waits for completion (with timeout), then drains
// N*N results from the output SRAM onto an outbound valid/ready stream.
// Ports: clk_i/rst_i; job_start_i, busy_o, job_done_o, error_o;
// s_* inbound stream; north_*/west_* queue writes; start/complete
// handshake with the array; read_* SRAM port; m_* result stream.
module systolic_host_sequencer
  import systolic_host_pkg::*;
#(
  parameter int N              = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          job_start_i,
  output logic                          busy_o,
  output logic                          job_done_o,
  output logic                          error_o,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [DATA_WIDTH-1:0]         s_data_i,
  output logic                          north_write_enable_o,
  output logic [DATA_WIDTH-1:0]         north_write_data_o,
  output logic                          north_write_reset_o,
  output logic                          west_write_enable_o,
  output logic [DATA_WIDTH-1:0]         west_write_data_o,
  output logic                          west_write_reset_o,
  output logic                          start_matrix_mult_o,
  input  logic                          matrix_mult_complete_i,
  input  logic                          collection_complete_i,
  output logic                          read_enable_o,
  output logic [$clog2(N*N)-1:0]        read_addr_o,
  input  logic [DATA_WIDTH-1:0]         read_data_i,
  input  logic                          read_valid_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [DATA_WIDTH-1:0]         m_data_o,
  output logic                          m_last_o
);

  localparam int AW = addr_w(N);
  localparam int CW = cnt_w(N);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] NN_M1 = CW'(N * N - 1);
  localparam logic [CW-1:0] NN    = CW'(N * N);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [TW-1:0]         tmo_q;
  logic                  nwe_q, wwe_q;
  logic                  nrst_q, wrst_q;
  logic [DATA_WIDTH-1:0] nwd_q, wwd_q;
  logic                  start_q, re_q;
  logic                  done_q, err_q;
  logic [AW-1:0]         raddr_q;
  logic                  mm_seen_q, cc_seen_q;
  logic                  infl_q, infl_last_q;
  logic                  mm_any, cc_any;
  logic [1:0]            fcnt;
  logic [DATA_WIDTH:0]   fhead;
  logic                  push, pop;

  assign mm_any = mm_seen_q | matrix_mult_complete_i;
  assign cc_any = cc_seen_q | collection_complete_i;
  // Only the single outstanding read may return a word.
  assign push = read_valid_i && infl_q;
  assign pop  = m_valid_o && m_ready_i;

  host_result_fifo #(.W(DATA_WIDTH + 1)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (state_q == CLR),
    .push_i  (push),
    .din_i   ({infl_last_q, read_data_i}),
    .pop_i   (pop),
    .count_o (fcnt),
    .head_o  (fhead)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      nwe_q       <= 1'b0;
      wwe_q       <= 1'b0;
      nrst_q      <= 1'b0;
      wrst_q      <= 1'b0;
      nwd_q       <= '0;
      wwd_q       <= '0;
      start_q     <= 1'b0;
      re_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      raddr_q     <= '0;
      mm_seen_q   <= 1'b0;
      cc_seen_q   <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      nwe_q   <= 1'b0;
      wwe_q   <= 1'b0;
      nrst_q  <= 1'b0;
      wrst_q  <= 1'b0;
      start_q <= 1'b0;
      re_q    <= 1'b0;
      done_q  <= 1'b0;
      if (push) infl_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (job_start_i) begin
            state_q <= CLR;
            err_q   <= 1'b0;
            nrst_q  <= 1'b1;
            wrst_q  <= 1'b1;
          end
        end
        CLR: begin
          cnt_q   <= '0;
          state_q <= LOAD_N;
        end
        LOAD_N: begin
          if (s_valid_i) begin
            nwe_q <= 1'b1;
            nwd_q <= s_data_i;
            if (cnt_q == NN_M1) begin
              cnt_q   <= '0;
              state_q <= LOAD_W;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        LOAD_W: begin
          if (s_valid_i) begin
            wwe_q <= 1'b1;
            wwd_q <= s_data_i;
            if (cnt_q == NN_M1) begin
              cnt_q   <= '0;
              state_q <= START;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        START: begin
          start_q   <= 1'b1;
          tmo_q     <= '0;
          mm_seen_q <= 1'b0;
          cc_seen_q <= 1'b0;
          state_q   <= WAIT_COMP;
        end
        WAIT_COMP: begin
          mm_seen_q <= mm_any;
          cc_seen_q <= cc_any;
          if (mm_any && cc_any) begin
            cnt_q   <= '0;
            infl_q  <= 1'b0;
            state_q <= DRAIN;
          end else if (tmo_q == TLAST) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        DRAIN: begin
          // Issue only when nothing is in flight and the FIFO has room,
          // so FIFO occupancy plus the outstanding read never exceeds 2.
          if (!infl_q && fcnt < 2'd2 && cnt_q < NN) begin
            re_q        <= 1'b1;
            raddr_q     <= cnt_q[AW-1:0];
            infl_q      <= 1'b1;
            infl_last_q <= (cnt_q == NN_M1);
            cnt_q       <= cnt_q + 1'b1;
          end
          if (pop && fhead[DATA_WIDTH]) begin
            done_q  <= 1'b1;
            state_q <= FINISH;
          end
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o               = (state_q != IDLE);
  assign s_ready_o            = (state_q == LOAD_N) ||
                                (state_q == LOAD_W);
  assign job_done_o           = done_q;
  assign error_o              = err_q;
  assign north_write_enable_o = nwe_q;
  assign north_write_data_o   = nwd_q;
  assign north_write_reset_o  = nrst_q;
  assign west_write_enable_o  = wwe_q;
  assign west_write_data_o    = wwd_q;
  assign west_write_reset_o   = wrst_q;
  assign start_matrix_mult_o  = start_q;
  assign read_enable_o        = re_q;
  assign read_addr_o          = raddr_q;
  assign m_valid_o            = (fcnt != 2'd0);
  assign m_data_o             = fhead[DATA_WIDTH-1:0];
  assign m_last_o             = fhead[DATA_WIDTH];

endmodule

// File: tb/tb_systolic_host_sequencer.sv
// Bench for systolic_host_sequencer with N=2 and a 16-cycle timeout.
// Stub array/SRAM plus queue-based expectations for each job.
module tb_systolic_host_sequencer;

  localparam int N   = 2;
  localparam int NN  = N * N;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          job_start_i;
  logic          busy_o, job_done_o, error_o;
  logic          s_valid_i, s_ready_o;
  logic [DW-1:0] s_data_i;
  logic          north_write_enable_o, north_write_reset_o;
  logic [DW-1:0] north_write_data_o;
  logic          west_write_enable_o, west_write_reset_o;
  logic [DW-1:0] west_write_data_o;
  logic          start_matrix_mult_o;
  logic          matrix_mult_complete_i, collection_complete_i;
  logic          read_enable_o;
  logic [1:0]    read_addr_o;
  logic [DW-1:0] read_data_i;
  logic          read_valid_i;
  logic          m_valid_o, m_ready_i, m_last_o;
  logic [DW-1:0] m_data_o;

  always #5 clk = ~clk;

  systolic_host_sequencer #(
    .N(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .job_start_i(job_start_i), .busy_o(busy_o),
    .job_done_o(job_done_o), .error_o(error_o),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_data_i(s_data_i),
    .north_write_enable_o(north_write_enable_o),
    .north_write_data_o(north_write_data_o),
    .north_write_reset_o(north_write_reset_o),
    .west_write_enable_o(west_write_enable_o),
    .west_write_data_o(west_write_data_o),
    .west_write_reset_o(west_write_reset_o),
    .start_matrix_mult_o(start_matrix_mult_o),
    .matrix_mult_complete_i(matrix_mult_complete_i),
    .collection_complete_i(collection_complete_i),
    .read_enable_o(read_enable_o), .read_addr_o(read_addr_o),
    .read_data_i(read_data_i), .read_valid_i(read_valid_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_data_o(m_data_o), .m_last_o(m_last_o)
  );

  logic [DW-1:0] stream [2*NN];
  logic [DW-1:0] res_mem [NN];
  int rmode;
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int cyc = 0;
  int re_b = 0;
  int pop_b = 0;
  int occ_viol = 0;
  logic err_prev = 1'b0;

  logic [DW-1:0] nq[$], wq[$], od[$];
  bit ol[$];
  int ra[$], re_c[$], pop_c[$], w_c[$];
  int nrst_c[$], wrst_c[$], start_c[$], done_c[$];
  int js_c[$], mm_c[$], cc_c[$], err_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Stub output SRAM: one-cycle read latency.
  always @(posedge clk) begin
    read_valid_i <= read_enable_o;
    read_data_i  <= res_mem[read_addr_o];
  end

  // Result-side ready pattern: 0 always, 1 random, 2 never.
  always @(posedge clk) begin
    #1;
    m_ready_i = (rmode == 0) ? 1'b1 :
                (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  always @(negedge clk) begin
    if (north_write_enable_o) nq.push_back(north_write_data_o);
    if (west_write_enable_o) begin
      wq.push_back(west_write_data_o);
      w_c.push_back(cyc);
    end
    if (north_write_reset_o) nrst_c.push_back(cyc);
    if (west_write_reset_o) wrst_c.push_back(cyc);
    if (start_matrix_mult_o) start_c.push_back(cyc);
    if (job_done_o) done_c.push_back(cyc);
    if (job_start_i && !busy_o && !rst_i) js_c.push_back(cyc);
    if (matrix_mult_complete_i) mm_c.push_back(cyc);
    if (collection_complete_i) cc_c.push_back(cyc);
    if (read_enable_o) begin
      ra.push_back(int'(read_addr_o));
      re_c.push_back(cyc);
    end
    if (m_valid_o && m_ready_i) begin
      od.push_back(m_data_o);
      ol.push_back(m_last_o);
      pop_c.push_back(cyc);
    end
    if (error_o && !err_prev) err_c.push_back(cyc);
    err_prev = error_o;
    // Words read but not yet accepted downstream.
    if ((ra.size() - re_b) - (od.size() - pop_b) > 2) occ_viol++;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ctl"},
        64'({busy_o, job_done_o, error_o, s_ready_o,
             north_write_enable_o, north_write_reset_o,
             west_write_enable_o, west_write_reset_o,
             start_matrix_mult_o, read_enable_o, read_addr_o,
             m_valid_o, m_last_o}), 64'd0);
    chk({tag, "_data"},
        64'(north_write_data_o | west_write_data_o | m_data_o), 64'd0);
    chk({tag, "_mvalid"}, 64'(m_valid_o), 64'd0);
  endtask

  task automatic send_stream(input bit gaps);
    int i;
    int g;
    bit hs;
    i = 0;
    g = 0;
    while (i < 2 * NN && g < 400) begin
      s_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data_i  = stream[i];
      @(negedge clk);
      hs = s_valid_i && s_ready_o;
      @(posedge clk);
      #1;
      if (hs) i++;
      g++;
    end
    s_valid_i = 1'b0;
    chk("stream_accepted", 64'(i), 64'(2 * NN));
  endtask

  // mode 0: full job, 1: expect timeout, 2: reset while results stalled
  task automatic run_job(input bit gaps, input int rm, input int mm_d,
                         input int cc_d, input int mode);
    int nb, wb, sb, db, eb, jb, nrb, wrb, vb, g;
    nb  = nq.size();
    wb  = wq.size();
    sb  = start_c.size();
    db  = done_c.size();
    eb  = err_c.size();
    jb  = js_c.size();
    nrb = nrst_c.size();
    wrb = wrst_c.size();
    vb  = occ_viol;
    re_b  = ra.size();
    pop_b = od.size();
    rmode = rm;
    @(posedge clk);
    #1 job_start_i = 1'b1;
    @(posedge clk);
    #1 job_start_i = 1'b0;
    chk("err_cleared", 64'(error_o), 64'd0);
    chk("busy_on_start", 64'(busy_o), 64'd1);
    send_stream(gaps);
    g = 0;
    while (start_c.size() == sb && g < 50) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("start_pulses", 64'(start_c.size() - sb), 64'd1);
    for (int t = 1; t <= 20; t++) begin
      matrix_mult_complete_i = (t == mm_d);
      collection_complete_i  = (t == cc_d);
      if (t == 1) begin
        chk("s_ready_wait", 64'(s_ready_o), 64'd0);
        chk("busy_wait", 64'(busy_o), 64'd1);
      end
      @(posedge clk);
      #1;
    end
    matrix_mult_complete_i = 1'b0;
    collection_complete_i  = 1'b0;

    chk("north_cnt", 64'(nq.size() - nb), 64'(NN));
    chk("west_cnt", 64'(wq.size() - wb), 64'(NN));
    for (int i = 0; i < NN; i++) begin
      if (nb + i < nq.size())
        chk($sformatf("north_d%0d", i), 64'(nq[nb+i]), 64'(stream[i]));
      if (wb + i < wq.size())
        chk($sformatf("west_d%0d", i), 64'(wq[wb+i]), 64'(stream[NN+i]));
    end
    if (w_c.size() > 0 && start_c.size() > sb)
      chk("start_after_west", 64'(start_c[sb] > w_c[w_c.size()-1]), 64'd1);
    chk("nrst_once", 64'(nrst_c.size() - nrb), 64'd1);
    chk("wrst_once", 64'(wrst_c.size() - wrb), 64'd1);
    if (nrst_c.size() > nrb && js_c.size() > jb)
      chk("nrst_cycle", 64'(nrst_c[nrb] - js_c[jb]), 64'd1);

    if (mode == 1) begin
      chk("timeout_rise", 64'(err_c.size() - eb), 64'd1);
      if (err_c.size() > eb && start_c.size() > sb)
        chk("timeout_delay", 64'(err_c[eb] - start_c[sb]), 64'(TMO));
      chk("timeout_err", 64'(error_o), 64'd1);
      chk("timeout_idle", 64'(busy_o), 64'd0);
      chk("timeout_no_reads", 64'(ra.size() - re_b), 64'd0);
      chk("timeout_no_out", 64'(od.size() - pop_b), 64'd0);
      chk("timeout_mvalid", 64'(m_valid_o), 64'd0);
    end else if (mode == 2) begin
      chk("stall_reads", 64'(ra.size() - re_b), 64'd2);
      chk("stall_mvalid", 64'(m_valid_o), 64'd1);
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      chk_idle_outputs("midjob_reset");
      rst_i = 1'b0;
      rmode = 0;
    end else begin
      g = 0;
      while (done_c.size() == db && g < 300) begin
        @(posedge clk);
        #1;
        g++;
      end
      chk("done_pulses", 64'(done_c.size() - db), 64'd1);
      chk("out_cnt", 64'(od.size() - pop_b), 64'(NN));
      chk("read_cnt", 64'(ra.size() - re_b), 64'(NN));
      for (int i = 0; i < NN; i++) begin
        if (pop_b + i < od.size()) begin
          chk($sformatf("m_data%0d", i), 64'(od[pop_b+i]), 64'(res_mem[i]));
          chk($sformatf("m_last%0d", i), 64'(ol[pop_b+i]),
              64'(i == NN - 1));
        end
        if (re_b + i < ra.size())
          chk($sformatf("raddr%0d", i), 64'(ra[re_b+i]), 64'(i));
      end
      if (done_c.size() > db && pop_c.size() >= pop_b + NN)
        chk("done_after_last",
            64'(done_c[db] - pop_c[pop_b+NN-1]), 64'd1);
      if (re_c.size() > re_b && mm_c.size() > 0 && cc_c.size() > 0)
        chk("drain_after_both",
            64'(re_c[re_b] > mm_c[mm_c.size()-1] &&
                re_c[re_b] > cc_c[cc_c.size()-1]), 64'd1);
      chk("occupancy", 64'(occ_viol - vb), 64'd0);
      chk("no_error", 64'(error_o), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("idle_after", 64'(busy_o), 64'd0);
      chk("done_single", 64'(done_c.size() - db), 64'd1);
    end
  endtask

  task automatic randomize_job();
    for (int i = 0; i < 2 * NN; i++) stream[i] = $urandom();
    for (int i = 0; i < NN; i++) res_mem[i] = $urandom();
  endtask

  initial begin
    rst_i = 1'b1;
    job_start_i = 1'b0;
    s_valid_i = 1'b0;
    s_data_i = '0;
    matrix_mult_complete_i = 1'b0;
    collection_complete_i = 1'b0;
    rmode = 0;
    for (int i = 0; i < NN; i++) res_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst_i = 1'b0;

    stream  = '{32'd1, 32'd0, 32'd0, 32'd1, 32'd5, 32'd6, 32'd7, 32'd8};
    res_mem = '{32'd5, 32'd6, 32'd7, 32'd8};
    run_job(1'b0, 0, 2, 2, 0);
    run_job(1'b0, 1, 2, 2, 0);

    randomize_job();
    run_job(1'b1, 1, 1, 3, 0);

    randomize_job();
    run_job(1'b0, 0, 2, 7, 0);
    randomize_job();
    run_job(1'b1, 1, 7, 2, 0);

    randomize_job();
    run_job(1'b0, 0, -1, -1, 1);
    randomize_job();
    run_job(1'b0, 1, 1, 1, 0);

    randomize_job();
    run_job(1'b0, 2, 1, 1, 2);
    randomize_job();
    run_job(1'b1, 1, 3, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
